// File: rtl/datamem_multiport_if.sv
// Bus bundle for datamem_multiport: cycle enable, write port, NUM_RD packed
// read ports and the clear-sweep handshake. The master drives requests and the
// slave (the memory) returns read data, valid flags and busy.
interface datamem_multiport_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) ();
    logic                     run;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic [NUM_RD*ADDR_W-1:0] raddr;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*DATA_W-1:0] rdata;
    logic [NUM_RD-1:0]        rvalid;
    logic                     clear_req;
    logic                     busy;

    modport master (
        output run, we, waddr, wdata, raddr, rd_en, clear_req,
        input  rdata, rvalid, busy
    );

    modport slave (
        input  run, we, waddr, wdata, raddr, rd_en, clear_req,
        output rdata, rvalid, busy
    );
endinterface

// File: rtl/datamem_multiport.sv
// datamem_multiport: 2**ADDR_W x DATA_W data memory with one write port,
// NUM_RD registered read ports and a sequenced clear engine (IDLE/CLEAR/DONE).
// Every state element advances only on a rising clock edge with run = 1.
// Optional feature macro: DATAMEM_BYPASS_EN -- when defined, a read that hits
// the address being written in the same cycle returns the new data
// (write-first); when undefined, reads return the old contents (read-first).
module datamem_multiport #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int NUM_RD = 2
) (
    input  logic                clock,
    input  logic                reset,
    datamem_multiport_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    // Counter is one bit wider than the address so the terminal value never aliases 0.
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    state_t                   state_q, state_d;
    logic [ADDR_W:0]          cnt_q, cnt_d;
    logic                     busy_q, busy_d;
    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rdata_q, rdata_d;
    logic [NUM_RD-1:0]        rvalid_q, rvalid_d;

    logic                     mem_we_s;
    logic [ADDR_W-1:0]        mem_waddr_s;
    logic [DATA_W-1:0]        mem_wdata_s;
    logic [ADDR_W-1:0]        rd_addr_s [NUM_RD];

    // Unpack the per-port read addresses.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_addr
        assign rd_addr_s[g] = bus.raddr[g*ADDR_W +: ADDR_W];
    end

    // Sweep FSM next state, counter, busy and the single memory write request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = bus.waddr;
        mem_wdata_s = bus.wdata;
        case (state_q)
            ST_IDLE: begin
                // A write coinciding with clear_req still lands; the sweep then zeroes it.
                mem_we_s = bus.we;
                if (bus.clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = cnt_q[ADDR_W-1:0];
                mem_wdata_s = '0;
                busy_d      = 1'b1;
                cnt_d       = cnt_q + (ADDR_W + 1)'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Per-port read data and valid flags; reads are accepted only in IDLE.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if ((state_q == ST_IDLE) && bus.rd_en[k]) begin
                rvalid_d[k] = 1'b1;
`ifdef DATAMEM_BYPASS_EN
                if (bus.we && (rd_addr_s[k] == bus.waddr)) begin
                    rdata_d[k*DATA_W +: DATA_W] = bus.wdata;
                end else begin
                    rdata_d[k*DATA_W +: DATA_W] = mem_q[rd_addr_s[k]];
                end
`else
                rdata_d[k*DATA_W +: DATA_W] = mem_q[rd_addr_s[k]];
`endif
            end else begin
                rvalid_d[k] = 1'b0;
            end
        end
    end

    // Control and output registers, advanced only on run-cycles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= '0;
        end else if (bus.run) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage array: zeroed by reset, one write per run-cycle (datapath or sweep).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.run && mem_we_s) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_datamem_multiport.sv
// Scoreboard bench for datamem_multiport: the driver advances a behavioural
// model one run-cycle at a time and queues expected read data per port; a
// monitor pops and compares whenever the DUT raises rvalid, and checks busy,
// rvalid and held rdata every cycle against the model.
module tb_datamem_multiport;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 16;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    datamem_multiport_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    datamem_multiport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference model state
    logic [7:0] ref_mem [DEPTH];
    int         mode;          // 0 idle, 1 sweeping, 2 finishing
    int         pos;           // next address the sweep zeroes
    logic       exp_busy;
    logic [1:0] exp_rvalid;
    logic       edge_active;   // the coming edge is a run-cycle
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] last_data [NUM_RD];

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        mode = 0;
        pos = 0;
        exp_busy = 1'b0;
        exp_rvalid = 2'b00;
        edge_active = 1'b0;
        q0.delete();
        q1.delete();
        for (int k = 0; k < NUM_RD; k++) last_data[k] = 8'h00;
    endtask

    // Assert reset right now (asynchronously), check outputs clear at once, release later.
    task automatic async_reset();
        reset = 1'b1;
        model_reset();
        #1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_rvalid", bus.rvalid, 2'b00);
        check("reset_rdata", bus.rdata, 16'h0000);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Drive one cycle's inputs and apply the behavioural rules for the coming edge.
    task automatic step(input bit r, input bit w, input int wa, input int wd,
                        input int ra0, input int ra1, input bit [1:0] re, input bit clr);
        int         ra;
        logic [7:0] d;
        logic [3:0] wa4;
        logic [7:0] wd8;
        @(negedge clock);
        wa4 = wa[3:0];
        wd8 = wd[7:0];
        bus.run       = r;
        bus.we        = w;
        bus.waddr     = wa4;
        bus.wdata     = wd8;
        bus.raddr     = {ra1[3:0], ra0[3:0]};
        bus.rd_en     = re;
        bus.clear_req = clr;
        edge_active   = r;
        if (r) begin
            if (mode == 0) begin
                for (int k = 0; k < NUM_RD; k++) begin
                    ra = (k == 0) ? ra0 : ra1;
                    if (re[k]) begin
                        d = ref_mem[ra % DEPTH];
`ifdef DATAMEM_BYPASS_EN
                        if (w && ((ra % DEPTH) == (wa % DEPTH))) d = wd8;
`endif
                        if (k == 0) q0.push_back(d);
                        else        q1.push_back(d);
                        exp_rvalid[k] = 1'b1;
                    end else begin
                        exp_rvalid[k] = 1'b0;
                    end
                end
                if (w) ref_mem[wa % DEPTH] = wd8;
                if (clr) begin
                    mode = 1;
                    pos = 0;
                    exp_busy = 1'b1;
                end
            end else if (mode == 1) begin
                exp_rvalid = 2'b00;
                ref_mem[pos] = 8'h00;
                pos++;
                if (pos == DEPTH) mode = 2;
                exp_busy = 1'b1;
            end else begin
                exp_rvalid = 2'b00;
                mode = 0;
                exp_busy = 1'b0;
            end
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b0, 0, 0, a, DEPTH - 1 - a, 2'b11, 1'b0);
        idle();
    endtask

    // Monitor: pops the scoreboard on DUT rvalid, checks busy/rvalid/rdata each cycle.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clock);
            #1;
            if (bus.busy === 1'b1) busy_cnt++;
            check("busy", bus.busy, exp_busy);
            check("rvalid", bus.rvalid, exp_rvalid);
            for (int k = 0; k < NUM_RD; k++) begin
                if (edge_active && !reset && bus.rvalid[k]) begin
                    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_rvalid%0d: got rvalid with no read pending at %0t", k, $time);
                    end else begin
                        e = (k == 0) ? q0.pop_front() : q1.pop_front();
                        last_data[k] = e;
                    end
                end
                check($sformatf("rdata%0d", k), bus.rdata[k*DATA_W +: DATA_W], last_data[k]);
            end
        end
    end

    initial begin
        bus.run = 1'b0; bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
        bus.raddr = '0; bus.rd_en = '0; bus.clear_req = 1'b0;
        model_reset();
        #2;
        async_reset();

        // Reset contents: everything reads zero.
        read_all();

        // Basic write then two-port read.
        step(1'b1, 1'b1, 3, 8'hA5, 0, 0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 0, 0, 3, 4, 2'b11, 1'b0);
        idle();

        // Same-cycle read and write to one address.
        step(1'b1, 1'b1, 7, 8'h11, 0, 0, 2'b00, 1'b0);
        step(1'b1, 1'b1, 7, 8'h5A, 7, 0, 2'b01, 1'b0);
        step(1'b1, 1'b0, 0, 0, 7, 7, 2'b11, 1'b0);
        idle();

        // Fill with 0xFF, clear with a simultaneous write; we/rd_en ignored while busy.
        for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b1, a, 8'hFF, 0, 0, 2'b00, 1'b0);
        idle();
        busy_cnt = 0;
        step(1'b1, 1'b1, 2, 8'h33, 2, 5, 2'b11, 1'b1);
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1, i % DEPTH, 8'hC3, i % DEPTH, 1, 2'b11, 1'b1);
        idle();
        check("busy_len_clear", busy_cnt, 17);
        read_all();

        // run = 0 in IDLE freezes memory and rvalid.
        step(1'b1, 1'b1, 9, 8'h42, 0, 0, 2'b00, 1'b0);
        step(1'b1, 1'b0, 0, 0, 9, 9, 2'b11, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 9, 8'h99, 9, 3, 2'b11, 1'b1);
        step(1'b1, 1'b0, 0, 0, 9, 0, 2'b01, 1'b0);
        idle();

        // run = 0 in the middle of a sweep: it pauses and resumes.
        for (int a = 0; a < DEPTH; a++) step(1'b1, 1'b1, a, a * 16 + 1, 0, 0, 2'b00, 1'b0);
        busy_cnt = 0;
        step(1'b1, 1'b0, 0, 0, 0, 0, 2'b00, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 13, 8'h77, 13, 14, 2'b11, 1'b1);
        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 13, 8'h77, 13, 14, 2'b11, 1'b0);
        idle();
        check("busy_len_paused", busy_cnt, 22);
        read_all();

        // Asynchronous reset mid-sweep (counter at 6).
        step(1'b1, 1'b1, 12, 8'hEE, 0, 0, 2'b00, 1'b0);
        step(1'b1, 1'b1, 15, 8'h77, 12, 12, 2'b11, 1'b0);
        step(1'b1, 1'b0, 0, 0, 0, 0, 2'b00, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 0, 0, 0, 0, 2'b00, 1'b0);
        @(negedge clock);
        #2;
        async_reset();
        read_all();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), $urandom_range(0, 1),
                 $urandom_range(0, 15), $urandom_range(0, 255),
                 $urandom_range(0, 15), $urandom_range(0, 15),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0));
        end
        for (int i = 0; i < 20; i++) idle();
        read_all();
        idle();

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/datamem_multiport.md
Name: datamem_multiport

Overview:
- Parametrised successor to the 16x8 data memory of the multicycle i281 CPU.
- Provides one write port and NUM_RD registered read ports, all gated by run.
- Adds a sequenced clear engine, busy indication and per-port read-valid flags.
- Sits between the datapath (address and operand muxes) and the register-file writeback mux.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 4, address width in bits; depth is 2**ADDR_W.
- NUM_RD, 2, number of independent read ports (1..4).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all words, outputs and FSM.
- run  input  1  cycle enable; when 0, all state holds (memory, outputs, FSM, counter).
- we  input  1  write enable (former c17).
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- raddr  input  NUM_RD*ADDR_W  packed read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- rd_en  input  NUM_RD  per-port read request.
- rdata  output  NUM_RD*DATA_W  packed registered read data.
- rvalid  output  NUM_RD  per-port valid, high for exactly one run-cycle after an accepted read.
- clear_req  input  1  starts a sequenced clear sweep.
- busy  output  1  high while the clear sweep is active.

Behaviour:
- Reset (asynchronous, immediate):
  - All 2**ADDR_W words = 0.
  - rdata = 0, rvalid = 0, busy = 0.
  - FSM = IDLE, sweep counter = 0.
- Reset mid-sweep aborts the sweep; the memory ends fully zeroed regardless.
- All sequential updates occur only on a rising clock edge with run = 1. With run = 0, everything holds, including rvalid.
- Write: in IDLE with we = 1, mem[waddr] <= wdata at the edge. Full address range is legal; no wrap is needed.
- Read, per port k:
  - In IDLE with rd_en[k] = 1: rdata[k] <= mem[raddr[k]] and rvalid[k] <= 1 at the edge. Latency is 1 run-cycle.
  - With rd_en[k] = 0: rvalid[k] <= 0 and rdata[k] holds its last value.
- Multiple ports may read the same address in the same cycle; each gets identical data.
- Read and write to the same address in the same cycle: read returns the OLD contents (read-first), unless DATAMEM_BYPASS_EN is defined.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR when clear_req = 1. The counter loads 0 and busy goes 1 at that edge.
  - CLEAR: each run-cycle, mem[counter] <= 0 and counter increments. After writing address 2**ADDR_W-1, go to DONE. The sweep takes exactly 2**ADDR_W run-cycles.
  - DONE: busy <= 0, go to IDLE next cycle. In DONE, clear_req is ignored.
  - During CLEAR and DONE, we and rd_en are ignored: no write, rvalid = 0, rdata holds.
  - clear_req while in CLEAR is ignored; the sweep does not restart.
- Simultaneous clear_req and we in IDLE: the write is performed at that edge, then the sweep begins and zeroes it.
- The counter is ADDR_W+1 bits wide, so the terminal compare does not wrap to 0.

Optional Feature:
- Macro: DATAMEM_BYPASS_EN.
- Defined: write-first forwarding. If we = 1, rd_en[k] = 1 and raddr[k] == waddr in IDLE, then rdata[k] <= wdata in the same edge.
- Undefined: read-first behaviour as specified above; no forwarding logic is synthesised.

Test Plan:
- Reset then read addr 0..15 on both ports -> rdata = 0x00 with rvalid pulsing one cycle after each request.
- Write 0xA5 to addr 3, next cycle read port0 addr 3, port1 addr 4 -> rdata0 = 0xA5, rdata1 = 0x00, rvalid = 2'b11 one cycle later.
- Same-cycle write 0x5A to addr 7 and read addr 7 (which holds 0x11):
  - Without macro -> rdata0 = 0x11.
  - With DATAMEM_BYPASS_EN -> rdata0 = 0x5A.
  - Following read returns 0x5A in both builds.
- Fill all words with 0xFF, pulse clear_req -> busy high for exactly 17 edges (16 CLEAR + 1 DONE); we/rd_en asserted meanwhile have no effect; all reads afterwards = 0x00.
- Hold run = 0 for 5 cycles with we = 1, rd_en = 1 and during a CLEAR sweep -> no memory change, rvalid frozen, sweep resumes at the same counter value.
- Assert reset asynchronously mid-sweep at counter 6 -> busy = 0 and rdata = 0 immediately; all words read 0x00; FSM in IDLE.
